// File: rtl/tbus_pkg.sv
// Shared types for the trinity-bus arbiter: FSM states and master identifiers.
package tbus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      OUTSTANDING,
      DONE_HOLD
   } tbus_state_e;

   localparam logic TBUS_MID_FETCH = 1'b0;
   localparam logic TBUS_MID_LSU   = 1'b1;

endpackage

// File: rtl/tbus_arbiter_rr_arb2.sv
// Two-way round-robin grant select; the priority bit is stored by the caller.
module rr_arb2
   import tbus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   output logic       sel
);

   // A lone requester always wins; prio only breaks ties (and parks sel when idle).
   always_comb begin
      sel = prio;
      case (req)
         2'b01:   sel = TBUS_MID_FETCH;
         2'b10:   sel = TBUS_MID_LSU;
         default: sel = prio;
      endcase
   end

endmodule

// File: rtl/tbus_arbiter.sv
// Shares one downstream tbus port between fetch (master 0) and the LSU (master 1),
// one transaction at a time, with round-robin grant and a sticky hung-slave watchdog.
`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 1:0
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'b00
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif
`ifndef RESULT_RANGE
`define RESULT_RANGE 63:0
`endif
`ifndef SRC_RANGE
`define SRC_RANGE 63:0
`endif

module tbus_arbiter
   import tbus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned RESET_PRIO     = 0
)(
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        m0_index_valid,
   output logic                        m0_index_ready,
   input  logic [`RESULT_RANGE]        m0_index,
   input  logic [`SRC_RANGE]           m0_write_data,
   input  logic [63:0]                 m0_write_mask,
   input  logic [`TBUS_OPTYPE_RANGE]   m0_operation_type,
   output logic [`RESULT_RANGE]        m0_read_data,
   output logic                        m0_operation_done,
   input  logic                        m1_index_valid,
   output logic                        m1_index_ready,
   input  logic [`RESULT_RANGE]        m1_index,
   input  logic [`SRC_RANGE]           m1_write_data,
   input  logic [63:0]                 m1_write_mask,
   input  logic [`TBUS_OPTYPE_RANGE]   m1_operation_type,
   output logic [`RESULT_RANGE]        m1_read_data,
   output logic                        m1_operation_done,
   output logic                        s_index_valid,
   input  logic                        s_index_ready,
   output logic [`RESULT_RANGE]        s_index,
   output logic [`SRC_RANGE]           s_write_data,
   output logic [63:0]                 s_write_mask,
   output logic [`TBUS_OPTYPE_RANGE]   s_operation_type,
   input  logic [`RESULT_RANGE]        s_read_data,
   input  logic                        s_operation_done,
   output logic                        busy,
   output logic                        owner,
   output logic                        err_timeout
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_SAT  = '1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic RST_PRIO = RESET_PRIO[0];

   tbus_state_e          state_q, state_d;
   logic                 prio_q, prio_d;
   logic                 owner_q, owner_d;
   logic [`RESULT_RANGE] hold_q, hold_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 arbSel, sel, fire;
   logic [`RESULT_RANGE] doneData;
   logic                 doneEn;

   rr_arb2 uArb (
      .req  ({m1_index_valid, m0_index_valid}),
      .prio (prio_q),
      .sel  (arbSel)
   );

   always_comb begin
      state_d           = state_q;
      prio_d            = prio_q;
      owner_d           = owner_q;
      hold_d            = hold_q;
      cnt_d             = '0;
      err_d             = err_q;
      sel               = (state_q == IDLE) ? arbSel : owner_q;
      fire              = 1'b0;
      doneEn            = 1'b0;
      doneData          = '0;
      s_index_valid     = 1'b0;
      s_index           = '0;
      s_write_data      = '0;
      s_write_mask      = '0;
      s_operation_type  = '0;
      m0_index_ready    = 1'b0;
      m1_index_ready    = 1'b0;
      m0_operation_done = 1'b0;
      m1_operation_done = 1'b0;
      m0_read_data      = '0;
      m1_read_data      = '0;

      case (state_q)
         IDLE, REQ: begin
            s_index_valid = sel ? m1_index_valid : m0_index_valid;
            if (s_index_valid) begin
               s_index          = sel ? m1_index          : m0_index;
               s_write_data     = sel ? m1_write_data     : m0_write_data;
               s_write_mask     = sel ? m1_write_mask     : m0_write_mask;
               s_operation_type = sel ? m1_operation_type : m0_operation_type;
               m0_index_ready   = ~sel & s_index_ready;
               m1_index_ready   =  sel & s_index_ready;
            end
            fire = s_index_valid & s_index_ready;
            // A done arriving with the fire cannot be handed over yet; park it for one cycle.
            if (fire) begin
               owner_d = sel;
               if (s_operation_done) begin
                  hold_d  = s_read_data;
                  state_d = DONE_HOLD;
               end else begin
                  state_d = OUTSTANDING;
               end
            end else if (s_index_valid) begin
               owner_d = sel;
               state_d = REQ;
            end
         end
         OUTSTANDING: begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
            if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !s_operation_done)
               err_d = 1'b1;
            if (s_operation_done) begin
               doneEn   = 1'b1;
               doneData = s_read_data;
            end
         end
         DONE_HOLD: begin
            doneEn   = 1'b1;
            doneData = hold_q;
         end
         default: state_d = IDLE;
      endcase

      // Completion goes only to the owner; the next arbitration waits a cycle.
      if (doneEn) begin
         prio_d  = ~owner_q;
         state_d = IDLE;
         if (owner_q) begin
            m1_operation_done = 1'b1;
            m1_read_data      = doneData;
         end else begin
            m0_operation_done = 1'b1;
            m0_read_data      = doneData;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         prio_q  <= RST_PRIO;
         owner_q <= RST_PRIO;
         hold_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign owner       = owner_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_tbus_arbiter.sv
// Scoreboard bench for tbus_arbiter: expected completions are queued as stimulus is
// driven and matched against master done pulses seen on the falling edge.
module tb_tbus_arbiter;

   localparam int TMO = 8;
   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        m0_index_valid, m1_index_valid;
   logic        m0_index_ready, m1_index_ready;
   logic [63:0] m0_index, m1_index, m0_write_data, m1_write_data;
   logic [63:0] m0_write_mask, m1_write_mask;
   logic [1:0]  m0_operation_type, m1_operation_type;
   logic [63:0] m0_read_data, m1_read_data;
   logic        m0_operation_done, m1_operation_done;
   logic        s_index_valid, s_index_ready;
   logic [63:0] s_index, s_write_data, s_write_mask, s_read_data;
   logic [1:0]  s_operation_type;
   logic        s_operation_done;
   logic        busy, owner, err_timeout;

   typedef struct {
      logic        mid;
      logic [63:0] data;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   assertCount = 0;
   int   failCount   = 0;
   int   doneCount   = 0;
   int   base;
   logic stallSeen   = 1'b0;

   tbus_arbiter #(.TIMEOUT_CYCLES(TMO), .RESET_PRIO(0)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0_index_valid(m0_index_valid), .m0_index_ready(m0_index_ready), .m0_index(m0_index),
      .m0_write_data(m0_write_data), .m0_write_mask(m0_write_mask),
      .m0_operation_type(m0_operation_type), .m0_read_data(m0_read_data),
      .m0_operation_done(m0_operation_done),
      .m1_index_valid(m1_index_valid), .m1_index_ready(m1_index_ready), .m1_index(m1_index),
      .m1_write_data(m1_write_data), .m1_write_mask(m1_write_mask),
      .m1_operation_type(m1_operation_type), .m1_read_data(m1_read_data),
      .m1_operation_done(m1_operation_done),
      .s_index_valid(s_index_valid), .s_index_ready(s_index_ready), .s_index(s_index),
      .s_write_data(s_write_data), .s_write_mask(s_write_mask),
      .s_operation_type(s_operation_type), .s_read_data(s_read_data),
      .s_operation_done(s_operation_done),
      .busy(busy), .owner(owner), .err_timeout(err_timeout)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input int m, input logic v, input logic [63:0] idx,
                                input logic [63:0] wd, input logic [63:0] mask, input logic [1:0] op);
      if (m == 0) begin
         m0_index_valid = v; m0_index = idx; m0_write_data = wd;
         m0_write_mask = mask; m0_operation_type = op;
      end else begin
         m1_index_valid = v; m1_index = idx; m1_write_data = wd;
         m1_write_mask = mask; m1_operation_type = op;
      end
   endtask

   task automatic expectDone(input logic mid, input logic [63:0] data);
      exp_t e;
      e.mid  = mid;
      e.data = data;
      expQ.push_back(e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic resetDut();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Done monitor, non-owner quiet check and the owner-holds-valid-in-REQ protocol check.
   always @(negedge clock) begin
      if (!reset_n) begin
         stallSeen = 1'b0;
      end else begin
         if (m0_operation_done || m1_operation_done) begin
            doneCount++;
            checkOutput("doneOneHot", {63'd0, m0_operation_done & m1_operation_done}, 64'd0);
            checkOutput("doneExpected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
               monE = expQ.pop_front();
               checkOutput("doneOwner", {63'd0, m1_operation_done}, {63'd0, monE.mid});
               checkOutput("doneData", m1_operation_done ? m1_read_data : m0_read_data, monE.data);
            end
         end
         if (!m0_operation_done) checkOutput("m0QuietData", m0_read_data, 64'd0);
         if (!m1_operation_done) checkOutput("m1QuietData", m1_read_data, 64'd0);
         if (stallSeen)
            assert (owner ? m1_index_valid : m0_index_valid)
               else $error("[TB] protocol: owner dropped valid while waiting for ready");
         stallSeen = s_index_valid && !s_index_ready;
      end
   end

   initial begin
      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, OP_READ);
      applyStimulus(1, 0, 0, 0, 0, OP_READ);
      s_index_ready = 0; s_operation_done = 0; s_read_data = 0;
      tick();
      tick();
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstOwner", owner, 0);
      checkOutput("rstErr", err_timeout, 0);
      checkOutput("rstSValid", s_index_valid, 0);
      checkOutput("rstM0Ready", m0_index_ready, 0);
      checkOutput("rstM1Done", m1_operation_done, 0);
      reset_n = 1'b1;
      tick();

      // Single m0 read, done three cycles after fire
      base = doneCount;
      applyStimulus(0, 1, 64'h8000_0000, 0, 0, OP_READ);
      s_index_ready = 1;
      #1;
      checkOutput("t1SValid", s_index_valid, 1);
      checkOutput("t1SIndex", s_index, 64'h8000_0000);
      checkOutput("t1M0Ready", m0_index_ready, 1);
      checkOutput("t1M1Ready", m1_index_ready, 0);
      expectDone(0, 64'h1122_3344_5566_7788);
      tick();
      applyStimulus(0, 0, 0, 0, 0, OP_READ);
      s_index_ready = 0;
      #1;
      checkOutput("t1BusyC1", busy, 1);
      checkOutput("t1SValidOut", s_index_valid, 0);
      tick();
      #1;
      checkOutput("t1BusyC2", busy, 1);
      tick();
      s_operation_done = 1; s_read_data = 64'h1122_3344_5566_7788;
      #1;
      checkOutput("t1BusyC3", busy, 1);
      checkOutput("t1M0Done", m0_operation_done, 1);
      checkOutput("t1M0Data", m0_read_data, 64'h1122_3344_5566_7788);
      checkOutput("t1M1Done", m1_operation_done, 0);
      tick();
      s_operation_done = 0; s_read_data = 0;
      #1;
      checkOutput("t1BusyEnd", busy, 0);
      checkOutput("t1DoneCount", doneCount - base, 1);

      // Both masters valid after reset: m0, then m1, then m0 again
      resetDut();
      base = doneCount;
      applyStimulus(0, 1, 64'h100, 0, 0, OP_READ);
      applyStimulus(1, 1, 64'h200, 0, 0, OP_READ);
      s_index_ready = 1;
      #1;
      checkOutput("t2FirstM0Ready", m0_index_ready, 1);
      checkOutput("t2FirstM1Ready", m1_index_ready, 0);
      checkOutput("t2FirstIndex", s_index, 64'h100);
      expectDone(0, 64'hA0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, OP_READ);
      s_index_ready = 0;
      #1;
      checkOutput("t2OutM1Ready", m1_index_ready, 0);
      tick();
      s_operation_done = 1; s_read_data = 64'hA0;
      #1;
      checkOutput("t2DoneCycleSValid", s_index_valid, 0);
      checkOutput("t2DoneCycleM1Ready", m1_index_ready, 0);
      tick();
      s_operation_done = 0; s_read_data = 0; s_index_ready = 1;
      #1;
      checkOutput("t2SecondM1Ready", m1_index_ready, 1);
      checkOutput("t2SecondIndex", s_index, 64'h200);
      checkOutput("t2SecondOwnerPrev", owner, 0);
      expectDone(1, 64'hA1);
      tick();
      applyStimulus(1, 0, 0, 0, 0, OP_READ);
      s_index_ready = 0;
      #1;
      checkOutput("t2SecondOwner", owner, 1);
      tick();
      s_operation_done = 1; s_read_data = 64'hA1;
      tick();
      s_operation_done = 0; s_read_data = 0; s_index_ready = 1;
      applyStimulus(0, 1, 64'h300, 0, 0, OP_READ);
      applyStimulus(1, 1, 64'h400, 0, 0, OP_READ);
      #1;
      checkOutput("t2ThirdM0Ready", m0_index_ready, 1);
      checkOutput("t2ThirdM1Ready", m1_index_ready, 0);
      checkOutput("t2ThirdIndex", s_index, 64'h300);
      expectDone(0, 64'hA2);
      tick();
      applyStimulus(0, 0, 0, 0, 0, OP_READ);
      applyStimulus(1, 0, 0, 0, 0, OP_READ);
      s_index_ready = 0;
      tick();
      s_operation_done = 1; s_read_data = 64'hA2;
      tick();
      s_operation_done = 0; s_read_data = 0;
      #1;
      checkOutput("t2DoneCount", doneCount - base, 3);

      // m1 write stalled in REQ; m0 request is locked out until m1 fires
      base = doneCount;
      applyStimulus(1, 1, 64'h500, 64'hCAFE_F00D, 64'hFF, OP_WRITE);
      #1;
      checkOutput("t3IdleSValid", s_index_valid, 1);
      checkOutput("t3IdleM1Ready", m1_index_ready, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 1) applyStimulus(0, 1, 64'h600, 0, 0, OP_READ);
         #1;
         checkOutput($sformatf("t3ReqBusy%0d", i), busy, 1);
         checkOutput($sformatf("t3ReqM0Ready%0d", i), m0_index_ready, 0);
         checkOutput($sformatf("t3ReqIndex%0d", i), s_index, 64'h500);
         checkOutput($sformatf("t3ReqMask%0d", i), s_write_mask, 64'hFF);
         checkOutput($sformatf("t3ReqWdata%0d", i), s_write_data, 64'hCAFE_F00D);
         checkOutput($sformatf("t3ReqOp%0d", i), {62'd0, s_operation_type}, {62'd0, OP_WRITE});
      end
      tick();
      s_index_ready = 1;
      #1;
      checkOutput("t3FireM1Ready", m1_index_ready, 1);
      checkOutput("t3FireM0Ready", m0_index_ready, 0);
      checkOutput("t3FireMask", s_write_mask, 64'hFF);
      expectDone(1, 64'h0);
      tick();
      applyStimulus(1, 0, 0, 0, 0, OP_READ);
      s_index_ready = 0;
      #1;
      checkOutput("t3OutSValid", s_index_valid, 0);
      tick();
      s_operation_done = 1;
      tick();
      s_operation_done = 0;
      applyStimulus(0, 0, 0, 0, 0, OP_READ);
      #1;
      checkOutput("t3EndBusy", busy, 0);
      checkOutput("t3DoneCount", doneCount - base, 1);

      // Ready and done together for an m1 read: done is delayed one cycle via the hold register
      base = doneCount;
      applyStimulus(1, 1, 64'h700, 0, 0, OP_READ);
      s_index_ready = 1; s_operation_done = 1; s_read_data = 64'hDEAD;
      #1;
      checkOutput("t4FireM1Ready", m1_index_ready, 1);
      checkOutput("t4FireNoDone", m1_operation_done, 0);
      expectDone(1, 64'hDEAD);
      tick();
      applyStimulus(1, 0, 0, 0, 0, OP_READ);
      s_index_ready = 0; s_operation_done = 0; s_read_data = 0;
      #1;
      checkOutput("t4HoldDone", m1_operation_done, 1);
      checkOutput("t4HoldData", m1_read_data, 64'hDEAD);
      checkOutput("t4HoldM0Done", m0_operation_done, 0);
      tick();
      #1;
      checkOutput("t4AfterDone", m1_operation_done, 0);
      checkOutput("t4AfterBusy", busy, 0);
      s_operation_done = 1; s_read_data = 64'hBEEF;
      #1;
      checkOutput("t4StrayM0", m0_operation_done, 0);
      checkOutput("t4StrayM1", m1_operation_done, 0);
      tick();
      s_operation_done = 0; s_read_data = 0;
      #1;
      checkOutput("t4DoneCount", doneCount - base, 1);

      // Async reset while m1 is outstanding, followed by a stray done
      base = doneCount;
      applyStimulus(1, 1, 64'h800, 0, 0, OP_READ);
      s_index_ready = 1;
      tick();
      applyStimulus(1, 0, 0, 0, 0, OP_READ);
      s_index_ready = 0;
      #1;
      checkOutput("t5PreOwner", owner, 1);
      checkOutput("t5PreBusy", busy, 1);
      tick();
      reset_n = 1'b0;
      #1;
      checkOutput("t5RstBusy", busy, 0);
      checkOutput("t5RstOwner", owner, 0);
      tick();
      tick();
      reset_n = 1'b1;
      s_operation_done = 1; s_read_data = 64'hBAD;
      #1;
      checkOutput("t5StrayM1", m1_operation_done, 0);
      checkOutput("t5StrayM0", m0_operation_done, 0);
      tick();
      s_operation_done = 0; s_read_data = 0;
      #1;
      checkOutput("t5Busy", busy, 0);
      checkOutput("t5Owner", owner, 0);
      checkOutput("t5DoneCount", doneCount - base, 0);

      // Watchdog: err after TMO outstanding cycles, sticky, done still delivered
      base = doneCount;
      applyStimulus(0, 1, 64'h900, 0, 0, OP_READ);
      s_index_ready = 1;
      expectDone(0, 64'h5A5A);
      tick();
      applyStimulus(0, 0, 0, 0, 0, OP_READ);
      s_index_ready = 0;
      for (int k = 1; k <= TMO; k++) begin
         checkOutput($sformatf("t6ErrLow%0d", k), err_timeout, 0);
         tick();
      end
      checkOutput("t6ErrRise", err_timeout, 1);
      checkOutput("t6StillBusy", busy, 1);
      repeat (3) tick();
      checkOutput("t6ErrSticky", err_timeout, 1);
      s_operation_done = 1; s_read_data = 64'h5A5A;
      #1;
      checkOutput("t6LateDone", m0_operation_done, 1);
      tick();
      s_operation_done = 0; s_read_data = 0;
      #1;
      checkOutput("t6IdleBusy", busy, 0);
      checkOutput("t6ErrAfterDone", err_timeout, 1);
      checkOutput("t6DoneCount", doneCount - base, 1);
      resetDut();
      checkOutput("t6ErrCleared", err_timeout, 0);

      checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/tbus_arbiter.md
Name: tbus_arbiter

Overview:
- Two-master, one-slave arbiter for the trinity bus (tbus).
- Shares the single downstream tbus port between the fetch unit (master 0) and the memblock load/store unit (master 1).
- Exactly one transaction is in flight at a time. Grant order is round-robin; the grant holds from request through operation_done.
- Routes read data and done back to the owning master only. A watchdog flags a hung slave.

Parameters:
- TIMEOUT_CYCLES, 1024, number of OUTSTANDING cycles without done before err_timeout sets; 0 disables the watchdog.
- RESET_PRIO, 0, master given priority after reset (0 = fetch, 1 = lsu).

Ports:
- clock  in  1  system clock
- reset_n  in  1  async active-low reset
- m0_index_valid / m1_index_valid  in  1  master request valid
- m0_index_ready / m1_index_ready  out  1  request accepted (fire = valid & ready)
- m0_index / m1_index  in  `RESULT_RANGE  address
- m0_write_data / m1_write_data  in  `SRC_RANGE  store data
- m0_write_mask / m1_write_mask  in  64  byte-lane bit mask
- m0_operation_type / m1_operation_type  in  `TBUS_OPTYPE_RANGE  `TBUS_READ / `TBUS_WRITE
- m0_read_data / m1_read_data  out  `RESULT_RANGE  read data, valid with done
- m0_operation_done / m1_operation_done  out  1  completion pulse
- s_index_valid  out  1  downstream request valid
- s_index_ready  in  1  downstream accept
- s_index  out  `RESULT_RANGE  forwarded address
- s_write_data  out  `SRC_RANGE  forwarded store data
- s_write_mask  out  64  forwarded byte-lane mask
- s_operation_type  out  `TBUS_OPTYPE_RANGE  forwarded op type
- s_read_data  in  `RESULT_RANGE  downstream read data
- s_operation_done  in  1  downstream completion pulse
- busy  out  1  state != IDLE
- owner  out  1  id of the current or last granted master
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset:
  - state = IDLE, prio = RESET_PRIO, owner = RESET_PRIO.
  - done_hold = 0, timeout counter = 0, err_timeout = 0.
  - All m*/s* outputs = 0.
- States: IDLE, REQ, OUTSTANDING, DONE_HOLD.
- IDLE:
  - Select the valid master. If both are valid, select prio.
  - Forward the selected master's index/data/mask/type to s_* combinationally in the same cycle (zero-latency request path).
  - s_index_valid = selected master's valid. The selected master's index_ready = s_index_ready; the other master's ready = 0.
  - Fire: owner <= sel, go to OUTSTANDING.
  - Valid but no ready: owner <= sel, go to REQ.
- REQ:
  - Grant locked to owner; the other master's request is ignored even if it asserts.
  - Forward owner's fields. Fire goes to OUTSTANDING.
  - Owner dropping valid in REQ is a protocol violation; the bench asserts it never happens.
- OUTSTANDING:
  - s_index_valid = 0; both index_ready = 0.
  - On s_operation_done: pulse m[owner]_operation_done and drive m[owner]_read_data = s_read_data in the same cycle. Then prio <= ~owner and go to IDLE.
  - The next arbitration begins the cycle after done, never the same cycle. This matches memblock, which deasserts mem_stall on done and re-presents valid only next cycle.
- Done in the fire cycle (s_operation_done & fire):
  - Masters only accept done after fire, so capture s_read_data into a hold register and go to DONE_HOLD.
  - In DONE_HOLD, pulse owner's done with the held data for one cycle, prio <= ~owner, go to IDLE.
- s_operation_done outside OUTSTANDING or a fire cycle: ignored; no master sees it.
- Non-owner outputs: operation_done = 0, read_data = 0 at all times.
- Watchdog:
  - Counter increments each cycle in OUTSTANDING and clears on leaving OUTSTANDING.
  - When counter == TIMEOUT_CYCLES-1 and no done arrives, err_timeout <= 1.
  - err_timeout is sticky until reset. The FSM keeps waiting.
  - Counter saturates at its maximum; width is $clog2(TIMEOUT_CYCLES+1).
- Async reset mid-transaction: immediately back to reset values. No done is delivered for the aborted transaction, and a late s_operation_done after reset is ignored (state IDLE).
- Single master requesting repeatedly: granted back-to-back regardless of prio, with one idle cycle between done and the next fire.

Decomposition:
- Shared package tbus_pkg:
  - state enum {IDLE, REQ, OUTSTANDING, DONE_HOLD}.
  - Master id constants TBUS_MID_FETCH = 0, TBUS_MID_LSU = 1.
- Existing `TBUS_READ / `TBUS_WRITE / `TBUS_OPTYPE_RANGE stay in defines.sv.
- One sub-module, rr_arb2: 2-way round-robin grant (inputs req[1:0], prio; output sel). Purely combinational; prio storage stays in tbus_arbiter.

Test Plan:
- m0 read, index 0x80000000, s_index_ready = 1, done 3 cycles later with s_read_data = 0x1122334455667788 -> m0_operation_done one cycle with that data; m1 outputs all 0; busy high 3 cycles.
- m0 and m1 both valid at reset (RESET_PRIO = 0) -> m0 granted first; after m0 done, m1 granted the cycle after done; if both request again, m0 is granted third.
- m1 write, mask 0x00000000000000FF, s_index_ready low 4 cycles -> state REQ 4 cycles; a new m0 request in REQ gets m0_index_ready = 0; s_write_mask stable at 0xFF until fire.
- s_index_ready and s_operation_done high in the same cycle for m1 read, data 0xDEAD -> m1_operation_done pulses exactly next cycle with 0xDEAD; then IDLE.
- reset_n low 2 cycles while OUTSTANDING, then a stray s_operation_done -> no master done pulse; owner = RESET_PRIO; busy = 0.
- TIMEOUT_CYCLES = 8, no done after fire -> err_timeout rises after 8 OUTSTANDING cycles and stays high; a later done still completes to the owner; err_timeout clears only on reset.
